bp_cfg_loader: RTL and testbench
================================

// Module: bp_cfg_loader
// PURPOSE
//  Post-reset sequencer that programs every core's configuration registers over the shared cfg link.
//  Sits beside the core complex and owns the single cfg bus master port.
//  Freezes all cores, writes core_id, icache mode and dcache mode per core, then unfreezes all cores.
//  Signals completion to the host/boot logic.
// PARAMETERS
//  num_core_p        1   cores to program; top sets cc_x_dim*cc_y_dim of the selected proc cfg
//  cfg_addr_width_p  16  cfg register address width
//  cfg_data_width_p  32  cfg register data width
//  core_id_width_p   8   width of cfg_core_o; must satisfy 2**core_id_width_p >= num_core_p
// PORTS
//  clk_i            in   1                 clock
//  reset_n_i        in   1                 async reset, active-low
//  start_i          in   1                 single-cycle start pulse
//  cfg_v_o          out  1                 cfg request valid
//  cfg_w_o          out  1                 1=write, 0=read
//  cfg_core_o       out  core_id_width_p   target core index
//  cfg_addr_o       out  cfg_addr_width_p  register address
//  cfg_data_o       out  cfg_data_width_p  write data
//  cfg_ready_i      in   1                 cfg bus accepts request when cfg_v_o&cfg_ready_i
//  cfg_resp_v_i     in   1                 read response valid (readback only)
//  cfg_resp_data_i  in   cfg_data_width_p  read response data (readback only)
//  busy_o           out  1                 sequence in progress
//  done_o           out  1                 sequence completed; sticky until next accepted start
//  error_o          out  1                 readback mismatch seen; sticky until next accepted start
// BEHAVIOUR
//  - Reset (async, reset_n_i=0): state=IDLE; core/step counters=0; all outputs 0.
//  - IDLE: start_i=1 -> FREEZE, core=0, step=0, done_o/error_o cleared next cycle; busy_o=1 from that cycle.
//  - start_i while busy_o=1 is ignored.
//  - FREEZE: per core, write addr 0x0001 data 1. Advance core on handshake. Last core -> PROG.
//  - PROG: per core, step 0: addr 0x0002 data=core index (zero-ext).
//    step 1: addr 0x0003 data 1. step 2: addr 0x0004 data 1.
//    step wraps 2->0 with core++. Last core step 2 -> UNFREEZE.
//  - UNFREEZE: per core, write addr 0x0001 data 0. Last core -> DONE.
//  - DONE: busy_o=0, done_o=1, one cycle, then IDLE (done_o held).
//  - Handshake: one request per transfer. cfg_v_o may assert the cycle after state entry.
//    While cfg_v_o&!cfg_ready_i, the core/addr/data/w outputs are held stable.
//    cfg_v_o never drops without a handshake. Request throughput is 1 per cycle when cfg_ready_i=1.
//  - Total writes = 5*num_core_p. With num_core_p=1 and ready=1, done_o rises start+7 cycles (writes at +1..+5).
//  - Counters are sized clog2(num_core_p) (safe-clog2) and compare to num_core_p-1; no wrap past the last core.
//  - Reset mid-sequence aborts immediately. No partial state survives. The bus sees cfg_v_o drop asynchronously.
// CONFIGURATION
//  BP_CFG_LOADER_READBACK_EN defined:
//  - After every accepted write, issue a read (cfg_w_o=0) to the same core/addr, then wait for cfg_resp_v_i.
//  - A response != written data sets error_o; the sequence continues regardless.
//  - Responses arriving when not awaiting one are ignored.
//  - Extra states: READ, WAIT_RESP.
//  Undefined:
//  - cfg_resp_* are unused. error_o is tied 0. cfg_w_o is always 1 when cfg_v_o=1.
// STRUCTURE
//  - Shared package bp_cfg_link_pkg holds:
//    - the cfg address constants (e_cfg_freeze=0x0001, e_cfg_core_id=0x0002, e_cfg_icache_mode=0x0003, e_cfg_dcache_mode=0x0004);
//    - the cache mode enum (e_cache_mode_normal=1);
//    - the loader state enum.
//  - No sub-module. One FSM plus core/step counters and a registered request bundle.
// TESTING
//  1. num_core_p=1, ready=1: start -> writes (c0,0x1,1),(c0,0x2,0),(c0,0x3,1),(c0,0x4,1),(c0,0x1,0) in order; done_o at +7.
//  2. num_core_p=4, ready toggling 1010: 20 writes. FREEZE covers c0..c3 before any 0x2. Outputs stable across every stall.
//  3. Start pulse during busy (cycle 3) -> no restart; exactly 5*num_core_p writes. Second start after done -> done_o clears, repeats.
//  4. reset_n_i low at write 3 of 5 -> cfg_v_o=0, busy_o=0, done_o=0 immediately. Restart yields a full clean sequence.
//  5. READBACK_EN, bus returns 0xDEAD for core_id read -> error_o=1 and stays set; sequence completes with done_o=1.
//  6. READBACK_EN, correct echoes, resp delay 3 cycles -> write/read alternate, error_o=0, 10 requests for num_core_p=1.

Source files
------------

// File: rtl/bp_cfg_link_pkg.sv
// Shared cfg-link definitions: register addresses, cache modes and the loader state encoding.
package bp_cfg_link_pkg;

  localparam logic [15:0] e_cfg_freeze      = 16'h0001;
  localparam logic [15:0] e_cfg_core_id     = 16'h0002;
  localparam logic [15:0] e_cfg_icache_mode = 16'h0003;
  localparam logic [15:0] e_cfg_dcache_mode = 16'h0004;

  typedef enum logic [1:0] {
    e_cache_mode_normal = 2'd1
  } bp_cache_mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StFreeze,
    StProg,
    StUnfreeze,
    StDone,
    StRead,
    StWaitResp
  } bp_cfg_loader_state_e;

endpackage

// File: rtl/bp_cfg_loader.sv
// Post-reset cfg sequencer: freeze, program core_id/icache/dcache mode per core, unfreeze.
// Define BP_CFG_LOADER_READBACK_EN to read back and verify every write.
module bp_cfg_loader
  import bp_cfg_link_pkg::*;
#(
  parameter int unsigned num_core_p       = 1,
  parameter int unsigned cfg_addr_width_p = 16,
  parameter int unsigned cfg_data_width_p = 32,
  parameter int unsigned core_id_width_p  = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        start_i,
  output logic                        cfg_v_o,
  output logic                        cfg_w_o,
  output logic [core_id_width_p-1:0]  cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ready_i,
  input  logic                        cfg_resp_v_i,
  input  logic [cfg_data_width_p-1:0] cfg_resp_data_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        error_o
);

  localparam int unsigned core_cnt_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;
  localparam logic [core_cnt_width_lp-1:0] last_core_lp = core_cnt_width_lp'(num_core_p - 1);
  localparam logic [core_cnt_width_lp-1:0] core_one_lp  = core_cnt_width_lp'(1);

  bp_cfg_loader_state_e state_q, state_d, ws;
  logic [core_cnt_width_lp-1:0] core_q, core_d;
  logic [1:0]                   step_q, step_d;
  logic                         done_q, done_d;
  logic                         adv;

  logic                        req_v_q, req_v_d;
  logic                        req_w_q, req_w_d;
  logic [core_id_width_p-1:0]  req_core_q, req_core_d;
  logic [cfg_addr_width_p-1:0] req_addr_q, req_addr_d;
  logic [cfg_data_width_p-1:0] req_data_q, req_data_d;

  logic hs;
  assign hs = req_v_q & cfg_ready_i;

`ifdef BP_CFG_LOADER_READBACK_EN
  bp_cfg_loader_state_e ret_q, ret_d;
  logic                 error_q, error_d;
`endif

  always_comb begin
    state_d = state_q;
    core_d  = core_q;
    step_d  = step_q;
    done_d  = done_q;
    adv     = 1'b0;
`ifdef BP_CFG_LOADER_READBACK_EN
    ret_d   = ret_q;
    error_d = error_q;
    ws      = ret_q;
`else
    ws      = state_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StFreeze;
          core_d  = '0;
          step_d  = '0;
          done_d  = 1'b0;
`ifdef BP_CFG_LOADER_READBACK_EN
          error_d = 1'b0;
`endif
        end
      end
      StFreeze, StProg, StUnfreeze: begin
        if (hs) begin
`ifdef BP_CFG_LOADER_READBACK_EN
          state_d = StRead;
          ret_d   = state_q;
`else
          adv     = 1'b1;
`endif
        end
      end
`ifdef BP_CFG_LOADER_READBACK_EN
      StRead: begin
        if (hs) state_d = StWaitResp;
      end
      StWaitResp: begin
        if (cfg_resp_v_i) begin
          adv = 1'b1;
          if (cfg_resp_data_i != req_data_q) error_d = 1'b1;
        end
      end
`endif
      StDone: begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Step past the write that just completed (ws is the write phase it belonged to).
    if (adv) begin
      unique case (ws)
        StFreeze: begin
          state_d = StFreeze;
          if (core_q == last_core_lp) begin
            state_d = StProg;
            core_d  = '0;
            step_d  = '0;
          end else begin
            core_d = core_q + core_one_lp;
          end
        end
        StProg: begin
          state_d = StProg;
          if (step_q == 2'd2) begin
            step_d = '0;
            if (core_q == last_core_lp) begin
              state_d = StUnfreeze;
              core_d  = '0;
            end else begin
              core_d = core_q + core_one_lp;
            end
          end else begin
            step_d = step_q + 2'd1;
          end
        end
        StUnfreeze: begin
          state_d = StUnfreeze;
          if (core_q == last_core_lp) begin
            state_d = StDone;
          end else begin
            core_d = core_q + core_one_lp;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Request bundle is rebuilt from next-state; unchanged state during a stall keeps it stable.
  always_comb begin
    req_v_d    = 1'b0;
    req_w_d    = req_w_q;
    req_core_d = req_core_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    unique case (state_d)
      StFreeze, StProg, StUnfreeze: begin
        req_v_d    = 1'b1;
        req_w_d    = 1'b1;
        req_core_d = core_id_width_p'(core_d);
        if (state_d == StProg) begin
          unique case (step_d)
            2'd0: begin
              req_addr_d = cfg_addr_width_p'(e_cfg_core_id);
              req_data_d = cfg_data_width_p'(core_d);
            end
            2'd1: begin
              req_addr_d = cfg_addr_width_p'(e_cfg_icache_mode);
              req_data_d = cfg_data_width_p'(e_cache_mode_normal);
            end
            default: begin
              req_addr_d = cfg_addr_width_p'(e_cfg_dcache_mode);
              req_data_d = cfg_data_width_p'(e_cache_mode_normal);
            end
          endcase
        end else begin
          req_addr_d = cfg_addr_width_p'(e_cfg_freeze);
          req_data_d = (state_d == StFreeze) ? cfg_data_width_p'(1) : '0;
        end
      end
`ifdef BP_CFG_LOADER_READBACK_EN
      StRead: begin
        req_v_d = 1'b1;
        req_w_d = 1'b0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= StIdle;
      core_q     <= '0;
      step_q     <= '0;
      done_q     <= 1'b0;
      req_v_q    <= 1'b0;
      req_w_q    <= 1'b0;
      req_core_q <= '0;
      req_addr_q <= '0;
      req_data_q <= '0;
    end else begin
      state_q    <= state_d;
      core_q     <= core_d;
      step_q     <= step_d;
      done_q     <= done_d;
      req_v_q    <= req_v_d;
      req_w_q    <= req_w_d;
      req_core_q <= req_core_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
    end
  end

`ifdef BP_CFG_LOADER_READBACK_EN
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ret_q   <= StIdle;
      error_q <= 1'b0;
    end else begin
      ret_q   <= ret_d;
      error_q <= error_d;
    end
  end
  assign error_o = error_q;
`else
  logic unused_resp;
  assign unused_resp = ^{cfg_resp_v_i, cfg_resp_data_i};
  assign error_o     = 1'b0;
`endif

  assign cfg_v_o    = req_v_q;
  assign cfg_w_o    = req_w_q;
  assign cfg_core_o = req_core_q;
  assign cfg_addr_o = req_addr_q;
  assign cfg_data_o = req_data_q;
  assign busy_o     = (state_q != StIdle) && (state_q != StDone);
  assign done_o     = done_q;

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Bench for bp_cfg_loader: one-core and four-core instances, bus-slave model with optional
// readback responder (BP_CFG_LOADER_READBACK_EN).
module tb_bp_cfg_loader;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]       start, rdy, resp_v, v, w, busy, done, err;
  logic [1:0][31:0] resp_data, data;
  logic [1:0][7:0]  core;
  logic [1:0][15:0] addr;

  bp_cfg_loader #(.num_core_p(1)) u_dut1 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start[0]),
    .cfg_v_o(v[0]), .cfg_w_o(w[0]), .cfg_core_o(core[0]), .cfg_addr_o(addr[0]),
    .cfg_data_o(data[0]), .cfg_ready_i(rdy[0]), .cfg_resp_v_i(resp_v[0]),
    .cfg_resp_data_i(resp_data[0]), .busy_o(busy[0]), .done_o(done[0]), .error_o(err[0])
  );

  bp_cfg_loader #(.num_core_p(4)) u_dut4 (
    .clk_i(clk), .reset_n_i(rst_n), .start_i(start[1]),
    .cfg_v_o(v[1]), .cfg_w_o(w[1]), .cfg_core_o(core[1]), .cfg_addr_o(addr[1]),
    .cfg_data_o(data[1]), .cfg_ready_i(rdy[1]), .cfg_resp_v_i(resp_v[1]),
    .cfg_resp_data_i(resp_data[1]), .busy_o(busy[1]), .done_o(done[1]), .error_o(err[1])
  );

  typedef struct {
    int          dut;
    int          cyc;
    logic        w;
    logic [7:0]  core;
    logic [15:0] addr;
    logic [31:0] data;
  } xfer_t;

  xfer_t       log_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          resp_delay = 1;
  bit          corrupt = 1'b0;
  int          rdy_mode[2];
  logic [31:0] mem[2][32];
  bit          pend_v[2];
  int          pend_due[2];
  logic [31:0] pend_dat[2];
  bit          stall[2];
  logic [57:0] held[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus slave: ready pattern and delayed read responses, driven just after the edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      case (rdy_mode[i])
        0:       rdy[i] = 1'b1;
        1:       rdy[i] = (cyc % 2 == 0);
        default: rdy[i] = 1'($urandom_range(0, 1));
      endcase
      resp_v[i]    = 1'b0;
      resp_data[i] = $urandom;
      if (pend_v[i] && cyc >= pend_due[i]) begin
        resp_v[i]    = 1'b1;
        resp_data[i] = pend_dat[i];
        pend_v[i]    = 1'b0;
      end
    end
  end

  // Transfer log and request-stability watch, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        stall[i]  = 1'b0;
        pend_v[i] = 1'b0;
      end else begin
        if (stall[i])
          chk(i == 0 ? "stable_u1" : "stable_u4", {6'd0, v[i], w[i], core[i], addr[i], data[i]},
              {6'd0, held[i]});
        if (v[i] && rdy[i]) begin
          log_q.push_back('{dut: i, cyc: cyc, w: w[i], core: core[i], addr: addr[i],
                            data: data[i]});
          if (w[i]) begin
            mem[i][int'(core[i][1:0]) * 8 + int'(addr[i][2:0])] = data[i];
          end else begin
            pend_v[i]   = 1'b1;
            pend_due[i] = cyc + resp_delay;
            pend_dat[i] = (corrupt && addr[i] == 16'h2) ? 32'hDEAD :
                          mem[i][int'(core[i][1:0]) * 8 + int'(addr[i][2:0])];
          end
        end
        stall[i] = v[i] && !rdy[i];
        held[i]  = {v[i], w[i], core[i], addr[i], data[i]};
      end
    end
  end

  // Expected order: freeze all cores, then (core_id, icache, dcache) per core, then unfreeze all.
  task automatic check_seq(input int d, input int nc, input string tag);
    xfer_t act[$];
    int    per, j, c, a, dt, m;
    per = 1;
`ifdef BP_CFG_LOADER_READBACK_EN
    per = 2;
`endif
    foreach (log_q[k]) if (log_q[k].dut == d) act.push_back(log_q[k]);
    chk($sformatf("%s_count", tag), act.size(), 5 * nc * per);
    for (int n = 0; n < 5 * nc; n++) begin
      if (n < nc) begin
        c = n; a = 1; dt = 1;
      end else if (n < 4 * nc) begin
        m = n - nc; c = m / 3; a = 2 + m % 3; dt = (m % 3 == 0) ? c : 1;
      end else begin
        c = n - 4 * nc; a = 1; dt = 0;
      end
      j = n * per;
      if (j < act.size())
        chk($sformatf("%s_wr%0d", tag, n), {act[j].w, act[j].core, act[j].addr, act[j].data},
            {1'b1, 8'(c), 16'(a), 32'(dt)});
      if (per == 2 && j + 1 < act.size())
        chk($sformatf("%s_rd%0d", tag, n), {act[j+1].w, act[j+1].core, act[j+1].addr},
            {1'b0, 8'(c), 16'(a)});
    end
  endtask

  task automatic pulse_start(input int d, output int s);
    @(posedge clk); #1;
    start[d] = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget && at < 0; k++) begin
      @(negedge clk);
      if (done[d]) at = cyc;
    end
    if (at < 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int s, at, s2;
    bit hit;
    rst_n = 1'b0;
    start = '0;
    rdy_mode[0] = 0;
    rdy_mode[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_u1", {v[0], busy[0], done[0], err[0], core[0], addr[0], data[0]}, 64'd0);
    chk("reset_u4", {v[1], busy[1], done[1], err[1], core[1], addr[1], data[1]}, 64'd0);
    rst_n = 1'b1;

    // One core, always ready: fixed latency.
    log_q.delete();
    pulse_start(0, s);
    wait_done(0, 200, at);
`ifndef BP_CFG_LOADER_READBACK_EN
    chk("t1_done_cycle", at, s + 7);
    for (int n = 0; n < 5 && n < log_q.size(); n++)
      chk($sformatf("t1_wr_cycle%0d", n), log_q[n].cyc, s + 1 + n);
`endif
    chk("t1_busy_at_done", busy[0], 1'b0);
    check_seq(0, 1, "t1");

    // Four cores, ready toggling.
    rdy_mode[1] = 1;
    log_q.delete();
    pulse_start(1, s);
    wait_done(1, 2000, at);
    check_seq(1, 4, "t2");

    // Start pulse while busy is ignored; random ready.
    rdy_mode[1] = 2;
    log_q.delete();
    pulse_start(1, s);
    @(posedge clk); #1;
    start[1] = 1'b1;
    @(posedge clk); #1;
    start[1] = 1'b0;
    wait_done(1, 2000, at);
    repeat (5) @(posedge clk);
    check_seq(1, 4, "t3a");
    log_q.delete();
    pulse_start(1, s2);
    @(negedge clk);
    chk("t3_done_cleared", {done[1], busy[1]}, 2'b01);
    wait_done(1, 2000, at);
    check_seq(1, 4, "t3b");

    // Reset during the third write aborts at once.
    rdy_mode[0] = 0;
    log_q.delete();
    pulse_start(0, s);
    hit = 1'b0;
    for (int k = 0; k < 50 && !hit; k++) begin
      @(negedge clk);
      if (v[0] && addr[0] == 16'h3) hit = 1'b1;
    end
    chk("t4_reached_write3", hit, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t4_abort", {v[0], busy[0], done[0]}, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    pulse_start(0, s);
    wait_done(0, 200, at);
    check_seq(0, 1, "t4");

    // Random ready on one core, repeated runs.
    rdy_mode[0] = 2;
    for (int r = 0; r < 3; r++) begin
      log_q.delete();
      pulse_start(0, s);
      wait_done(0, 500, at);
      check_seq(0, 1, $sformatf("rnd%0d", r));
    end

`ifdef BP_CFG_LOADER_READBACK_EN
    // Corrupted core_id echo flags error but the sequence completes.
    corrupt = 1'b1;
    resp_delay = 1;
    log_q.delete();
    pulse_start(0, s);
    wait_done(0, 500, at);
    chk("t5_error_done", {err[0], done[0]}, 2'b11);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t5_error_sticky", err[0], 1'b1);
    check_seq(0, 1, "t5");

    // Correct echoes with three-cycle response delay.
    corrupt = 1'b0;
    resp_delay = 3;
    rdy_mode[0] = 0;
    log_q.delete();
    pulse_start(0, s);
    @(negedge clk);
    chk("t6_error_cleared", err[0], 1'b0);
    wait_done(0, 500, at);
    chk("t6_no_error", err[0], 1'b0);
    check_seq(0, 1, "t6");
`else
    chk("err_tied_u1", err[0], 1'b0);
    chk("err_tied_u4", err[1], 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
